// File: rtl/surf_command_receiver.sv
// SURF-side decoder for the TURF->SURF serial command line: deserializes 36-bit
// frames into event ID / buffer number and keeps saturating frame/error counts.
module surf_command_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   CMD_i,
  output logic [31:0]            event_id_o,
  output logic [1:0]             buffer_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   frame_err_o,
  output logic [COUNT_WIDTH-1:0] frame_count_o,
  output logic [COUNT_WIDTH-1:0] err_count_o
);

  localparam int unsigned DATA_BITS = 34;
  localparam int unsigned BCNT_W    = 6;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DATA     = 2'd1;
  localparam logic [1:0] S_STOP     = 2'd2;
  localparam logic [1:0] S_WAIT_LOW = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;

  logic [1:0]             state_q, state_d;
  logic [BCNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   sr_q, sr_d;
  logic [31:0]            event_id_q, event_id_d;
  logic [1:0]             buffer_q, buffer_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   frame_err_q, frame_err_d;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;

  // Synchronizer chain: new sample enters at bit 0, s taken from the far end.
  assign sync_d = SYNC_STAGES'({sync_q, CMD_i});
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q        <= '0;
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      sr_q          <= '0;
      event_id_q    <= '0;
      buffer_q      <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      sr_q          <= sr_d;
      event_id_q    <= event_id_d;
      buffer_q      <= buffer_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  // Frame FSM; data enters at the MSB so an LSB-first frame ends right-aligned.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    sr_d          = sr_q;
    event_id_d    = event_id_q;
    buffer_d      = buffer_q;
    valid_d       = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (s) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        sr_d      = {s, sr_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        if (bit_cnt_q == BCNT_W'(DATA_BITS - 1)) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!s) begin
          event_id_d = sr_q[DATA_BITS-1:2];
          buffer_d   = sr_q[1:0];
          valid_d    = 1'b1;
          if (frame_count_q != {COUNT_WIDTH{1'b1}}) begin
            frame_count_d = frame_count_q + COUNT_WIDTH'(1);
          end
          state_d = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          if (err_count_q != {COUNT_WIDTH{1'b1}}) begin
            err_count_d = err_count_q + COUNT_WIDTH'(1);
          end
          state_d = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign event_id_o    = event_id_q;
  assign buffer_o      = buffer_q;
  assign valid_o       = valid_q;
  assign busy_o        = busy_q;
  assign frame_err_o   = frame_err_q;
  assign frame_count_o = frame_count_q;
  assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_surf_command_receiver.sv
// Bench for surf_command_receiver: four builds (SYNC 2/2/1/3, CW 16/4/16/16) share one
// CMD line; a frame-level model predicts pulse timing, busy windows, outputs and counts.
module tb_surf_command_receiver;

  localparam int unsigned ND = 4;

  typedef struct {
    int unsigned at;
    bit          good;
    logic [31:0] evt;
    logic [1:0]  bufn;
  } exp_t;

  typedef struct {
    int unsigned lo;
    int unsigned hi;
  } iv_t;

  logic clk = 1'b0;
  logic rst;
  logic cmd;

  logic [31:0] evt_w  [ND];
  logic [1:0]  buf_w  [ND];
  logic        val_w  [ND];
  logic        busy_w [ND];
  logic        err_w  [ND];
  logic [15:0] fc_w   [ND];
  logic [15:0] ec_w   [ND];
  logic [3:0]  fc4, ec4;

  int unsigned edge_n = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  int          sync_s [ND] = '{2, 2, 1, 3};
  int          cmax   [ND] = '{65535, 15, 65535, 65535};

  exp_t        exp_q  [ND][$];
  iv_t         bq     [ND][$];
  logic [31:0] m_evt  [ND];
  logic [1:0]  m_buf  [ND];
  int          m_fc   [ND];
  int          m_ec   [ND];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  surf_command_receiver #(.SYNC_STAGES(2), .COUNT_WIDTH(16)) u_s2 (
    .clk_i(clk), .rst_i(rst), .CMD_i(cmd),
    .event_id_o(evt_w[0]), .buffer_o(buf_w[0]), .valid_o(val_w[0]), .busy_o(busy_w[0]),
    .frame_err_o(err_w[0]), .frame_count_o(fc_w[0]), .err_count_o(ec_w[0]));

  surf_command_receiver #(.SYNC_STAGES(2), .COUNT_WIDTH(4)) u_cw4 (
    .clk_i(clk), .rst_i(rst), .CMD_i(cmd),
    .event_id_o(evt_w[1]), .buffer_o(buf_w[1]), .valid_o(val_w[1]), .busy_o(busy_w[1]),
    .frame_err_o(err_w[1]), .frame_count_o(fc4), .err_count_o(ec4));

  surf_command_receiver #(.SYNC_STAGES(1), .COUNT_WIDTH(16)) u_s1 (
    .clk_i(clk), .rst_i(rst), .CMD_i(cmd),
    .event_id_o(evt_w[2]), .buffer_o(buf_w[2]), .valid_o(val_w[2]), .busy_o(busy_w[2]),
    .frame_err_o(err_w[2]), .frame_count_o(fc_w[2]), .err_count_o(ec_w[2]));

  surf_command_receiver #(.SYNC_STAGES(3), .COUNT_WIDTH(16)) u_s3 (
    .clk_i(clk), .rst_i(rst), .CMD_i(cmd),
    .event_id_o(evt_w[3]), .buffer_o(buf_w[3]), .valid_o(val_w[3]), .busy_o(busy_w[3]),
    .frame_err_o(err_w[3]), .frame_count_o(fc_w[3]), .err_count_o(ec_w[3]));

  assign fc_w[1] = 16'(fc4);
  assign ec_w[1] = 16'(ec4);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got=%0h expected=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      exp_q[d].delete();
      bq[d].delete();
      m_evt[d] = '0;
      m_buf[d] = '0;
      m_fc[d]  = 0;
      m_ec[d]  = 0;
    end
  endtask

  // Called at the falling edge: retire due events, then compare every output.
  task automatic monitor();
    exp_t e;
    bit   ev, ee, eb;
    for (int d = 0; d < ND; d++) begin
      ev = 1'b0;
      ee = 1'b0;
      if (exp_q[d].size() != 0 && exp_q[d][0].at == edge_n) begin
        e = exp_q[d].pop_front();
        if (e.good) begin
          ev       = 1'b1;
          m_evt[d] = e.evt;
          m_buf[d] = e.bufn;
          if (m_fc[d] < cmax[d]) m_fc[d]++;
        end else begin
          ee = 1'b1;
          if (m_ec[d] < cmax[d]) m_ec[d]++;
        end
      end
      while (bq[d].size() != 0 && bq[d][0].hi < edge_n) void'(bq[d].pop_front());
      eb = (bq[d].size() != 0) && (bq[d][0].lo <= edge_n);
      check($sformatf("valid%0d", d), 64'(val_w[d]), 64'(ev));
      check($sformatf("ferr%0d", d), 64'(err_w[d]), 64'(ee));
      check($sformatf("busy%0d", d), 64'(busy_w[d]), 64'(eb));
      check($sformatf("evt%0d", d), 64'(evt_w[d]), 64'(m_evt[d]));
      check($sformatf("buf%0d", d), 64'(buf_w[d]), 64'(m_buf[d]));
      check($sformatf("fcnt%0d", d), 64'(fc_w[d]), 64'(m_fc[d]));
      check($sformatf("ecnt%0d", d), 64'(ec_w[d]), 64'(m_ec[d]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b);
    cmd = b;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cmd = 1'b0;
    model_clear();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // k = cycles the stop slot is held high (0 = good stop); abort >= 0 resets at that data bit.
  task automatic send_frame(input logic [31:0] evt, input logic [1:0] bufn,
                            input int k, input int abort);
    logic [33:0] data;
    exp_t        e;
    iv_t         iv;
    int unsigned e0;
    data = {evt, bufn};
    e0   = edge_n + 1;
    for (int d = 0; d < ND; d++) begin
      iv.lo = e0 + sync_s[d];
      if (abort < 0) begin
        e.at   = e0 + 35 + sync_s[d];
        e.good = (k == 0);
        e.evt  = evt;
        e.bufn = bufn;
        exp_q[d].push_back(e);
        iv.hi  = e0 + 34 + sync_s[d] + k;
      end else begin
        iv.hi  = 32'hFFFF_FFFF;
      end
      bq[d].push_back(iv);
    end
    drive(1'b1);
    for (int i = 0; i < 34; i++) begin
      if (i == abort) begin
        do_reset(5);
        return;
      end
      drive(data[i]);
    end
    repeat (k) drive(1'b1);
    drive(1'b0);
  endtask

  initial begin
    logic [31:0] r_evt;
    logic [1:0]  r_buf;
    int          k;
    rst = 1'b1;
    cmd = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    repeat (3) tick();
    rst = 1'b0;

    idle(100);
    send_frame(32'hDEADBEEF, 2'd2, 0, -1);
    idle(5);
    check("t1_evt", 64'(evt_w[0]), 64'h0000_0000_DEAD_BEEF);
    check("t1_buf", 64'(buf_w[0]), 64'd2);
    check("t1_fcnt", 64'(fc_w[0]), 64'd1);
    check("t1_ecnt", 64'(ec_w[0]), 64'd0);

    send_frame(32'h0000_0001, 2'd1, 3, -1);
    idle(5);
    check("t2_evt_held", 64'(evt_w[0]), 64'h0000_0000_DEAD_BEEF);
    check("t2_ecnt", 64'(ec_w[0]), 64'd1);

    send_frame(32'h12345678, 2'd0, 0, -1);
    idle(1);
    send_frame(32'h87654321, 2'd3, 0, -1);
    idle(5);
    check("t3_evt", 64'(evt_w[0]), 64'h0000_0000_8765_4321);
    check("t3_fcnt", 64'(fc_w[0]), 64'd3);

    send_frame(32'hFFFFFFFF, 2'd3, 0, -1);
    idle(2);
    send_frame(32'h00000000, 2'd0, 0, -1);
    idle(5);
    check("t6_ecnt_s3", 64'(ec_w[3]), 64'd1);
    check("t6_fcnt_s1", 64'(fc_w[2]), 64'd5);

    idle(3);
    send_frame(32'h13579BDF, 2'd2, 0, 10);
    check("t4_evt", 64'(evt_w[0]), 64'd0);
    check("t4_fcnt", 64'(fc_w[0]), 64'd0);
    idle(2);
    send_frame(32'hA5A5A5A5, 2'd1, 0, -1);
    idle(5);
    check("t4_evt_after", 64'(evt_w[0]), 64'h0000_0000_A5A5_A5A5);
    check("t4_buf_after", 64'(buf_w[0]), 64'd1);

    for (int i = 0; i < 20; i++) begin
      r_evt = $urandom();
      r_buf = 2'($urandom_range(0, 3));
      send_frame(r_evt, r_buf, 0, -1);
      idle($urandom_range(0, 2));
    end
    idle(5);
    check("t5_fcnt_sat", 64'(fc_w[1]), 64'd15);
    check("t5_fcnt_wide", 64'(fc_w[0]), 64'd21);

    for (int i = 0; i < 8; i++) begin
      r_evt = $urandom();
      r_buf = 2'($urandom_range(0, 3));
      k     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_frame(r_evt, r_buf, k, -1);
      idle($urandom_range(0, 2));
    end
    idle(10);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("pending%0d", d), 64'(exp_q[d].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
